key_loader: RTL and testbench
=============================

KEY_LOADER -- requirements
Module: key_loader

Interface
REQ-001 SHALL have parameter KEY_WIDTH, default 2: number of key bits delivered to the locked netlist (key_0..key_{KEY_WIDTH-1}), legal range 1..64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port load_start  input  1  one-cycle request to begin a key load.
REQ-005 SHALL have port load_abort  input  1  cancel any load in progress and return to idle.
REQ-006 SHALL have port sdi  input  1  serial key/parity bit.
REQ-007 SHALL have port sdi_valid  input  1  sdi holds a valid bit this cycle.
REQ-008 SHALL have port sdi_ready  output  1  loader accepts a bit this cycle; a transfer occurs when sdi_valid and sdi_ready are both 1.
REQ-009 SHALL have port key  output  KEY_WIDTH  key vector to the locked netlist; bit i drives key_i.
REQ-010 SHALL have port key_valid  output  1  key holds a parity-checked loaded value.
REQ-011 SHALL have port busy  output  1  load in progress (SHIFT or CHECK).
REQ-012 SHALL have port err  output  1  last load failed its parity check.

Function
REQ-013 SHALL implement the states IDLE, SHIFT, CHECK, DONE, ERROR.
REQ-014 IDLE/DONE/ERROR + load_start=1 SHALL go to SHIFT next cycle, and on that same edge SHALL clear the shadow register, bit counter, key, key_valid and err to 0.
REQ-015 SHIFT SHALL drive sdi_ready=1; sdi_ready SHALL be 0 in every other state.
REQ-016 SHIFT, per transfer: SHALL write the first KEY_WIDTH transfers LSB-first (transfer n -> shadow[n]); transfer KEY_WIDTH SHALL be the parity bit; the counter SHALL hold when no transfer occurs.
REQ-017 Accepting the parity bit SHALL move the FSM to CHECK; CHECK SHALL last exactly one cycle.
REQ-018 CHECK: if XOR(shadow) equals the parity bit (even parity over key plus parity), the FSM SHALL enter DONE with key=shadow and key_valid=1, both registered on the CHECK->DONE edge.
REQ-019 CHECK on a parity mismatch SHALL enter ERROR with key=0, key_valid=0, err=1.
REQ-020 key SHALL change only on the CHECK->DONE edge or when cleared (REQ-014, REQ-022, reset); no partial key SHALL ever reach the key output.
REQ-021 Latency: the first key_valid=1 cycle SHALL be exactly 2 cycles after the clock edge that accepts the parity bit.
REQ-022 load_abort=1 in any state SHALL force IDLE next cycle and clear the shadow, counter, key, key_valid and err; load_abort SHALL take priority over load_start and over a transfer in the same cycle.
REQ-023 load_start while in SHIFT or CHECK SHALL be ignored.
REQ-024 busy SHALL be 1 exactly in SHIFT and CHECK.
REQ-025 DONE and ERROR SHALL hold their outputs indefinitely until load_start, load_abort or reset.
REQ-026 The bit counter SHALL be ceil(log2(KEY_WIDTH+1)) bits wide and SHALL never exceed KEY_WIDTH.

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for a clock edge, force IDLE, key=0, key_valid=0, err=0, busy=0, sdi_ready=0 and the counter to 0.
REQ-028 Reset asserted mid-load SHALL discard all shifted bits; after release the FSM SHALL wait in IDLE for a new load_start.

Verification (KEY_WIDTH=2)
REQ-029 Reset release, load_start pulse, transfers 1,0, then parity 1 -> key=2'b01, key_valid=1 two cycles after the parity edge, err=0.
REQ-030 Transfers 1,1 with parity 1 -> ERROR: key=2'b00, key_valid=0, err=1.
REQ-031 sdi_valid toggled 1,0,0,1,1 with bits 0,x,x,1,1 -> key=2'b10, key_valid=1; stall cycles consume no bit.
REQ-032 load_abort asserted after the first transfer, in the same cycle as a transfer -> IDLE, busy=0, key=0; a following clean load of 1,1, parity 0 -> key=2'b11.
REQ-033 rst_n pulled low during SHIFT, between clock edges -> outputs cleared before the next edge; load_start pulsed in SHIFT is ignored (counter unchanged).
REQ-034 Reload from DONE (key=2'b01) -> key=0 and key_valid=0 on the load_start edge, then the new key is presented after its check.

Source files
------------

// File: rtl/key_loader.sv
// key_loader: serial key loader for a logic-locked netlist.
//
// Shifts KEY_WIDTH key bits in LSB-first, then one even-parity bit. The
// shadow register is checked against the parity bit in a one-cycle CHECK
// state. The key output is updated only on a successful check, so a
// partially loaded key never reaches the locked netlist.
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - asynchronous active-low reset
//   load_start - one-cycle request to begin a load (from IDLE/DONE/ERROR)
//   load_abort - cancel any load and return to IDLE (highest priority)
//   sdi        - serial key/parity bit
//   sdi_valid  - sdi holds a valid bit this cycle
//   sdi_ready  - loader accepts a bit this cycle (SHIFT only)
//   key        - key vector to the locked netlist
//   key_valid  - key holds a parity-checked value
//   busy       - load in progress (SHIFT or CHECK)
//   err        - last load failed its parity check
module key_loader #(
    parameter int unsigned KEY_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_start,
    input  logic                 load_abort,
    input  logic                 sdi,
    input  logic                 sdi_valid,
    output logic                 sdi_ready,
    output logic [KEY_WIDTH-1:0] key,
    output logic                 key_valid,
    output logic                 busy,
    output logic                 err
);

    localparam int unsigned CNT_W = $clog2(KEY_WIDTH + 1);

    typedef enum logic [2:0] {
        StIdle,
        StShift,
        StCheck,
        StDone,
        StError
    } state_e;

    state_e               state_q, state_d;
    logic [KEY_WIDTH-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 parity_q, parity_d;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic                 key_valid_q, key_valid_d;
    logic                 err_q, err_d;
    logic                 xfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            shadow_q    <= '0;
            cnt_q       <= '0;
            parity_q    <= 1'b0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            cnt_q       <= cnt_d;
            parity_q    <= parity_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        cnt_d       = cnt_q;
        parity_d    = parity_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        err_d       = err_q;
        xfer        = sdi_valid && (state_q == StShift);

        if (load_abort) begin
            state_d     = StIdle;
            shadow_d    = '0;
            cnt_d       = '0;
            parity_d    = 1'b0;
            key_d       = '0;
            key_valid_d = 1'b0;
            err_d       = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone, StError: begin
                    if (load_start) begin
                        state_d     = StShift;
                        shadow_d    = '0;
                        cnt_d       = '0;
                        parity_d    = 1'b0;
                        key_d       = '0;
                        key_valid_d = 1'b0;
                        err_d       = 1'b0;
                    end
                end
                StShift: begin
                    if (xfer) begin
                        if (cnt_q == CNT_W'(KEY_WIDTH)) begin
                            // Counter parks at KEY_WIDTH; this transfer is the parity bit.
                            parity_d = sdi;
                            state_d  = StCheck;
                        end else begin
                            for (int i = 0; i < KEY_WIDTH; i++) begin
                                if (cnt_q == CNT_W'(i)) begin
                                    shadow_d[i] = sdi;
                                end
                            end
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                StCheck: begin
                    // Even parity: XOR over key bits must equal the parity bit.
                    if ((^shadow_q) == parity_q) begin
                        state_d     = StDone;
                        key_d       = shadow_q;
                        key_valid_d = 1'b1;
                    end else begin
                        state_d     = StError;
                        key_d       = '0;
                        key_valid_d = 1'b0;
                        err_d       = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign sdi_ready = (state_q == StShift);
    assign busy      = (state_q == StShift) || (state_q == StCheck);
    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign err       = err_q;

endmodule

// File: tb/tb_key_loader.sv
// tb_key_loader: scoreboard bench for key_loader (KEY_WIDTH = 2).
// The driver pushes the expected outcome of each load into a queue; the
// monitor pops and compares whenever key_valid or err rises.
module tb_key_loader;

    localparam int unsigned KW = 2;

    logic          clk;
    logic          rst_n;
    logic          load_start;
    logic          load_abort;
    logic          sdi;
    logic          sdi_valid;
    logic          sdi_ready;
    logic [KW-1:0] key;
    logic          key_valid;
    logic          busy;
    logic          err;

    typedef struct packed {
        logic [KW-1:0] k;
        logic          v;
        logic          e;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic prev_ev = 1'b0;

    key_loader #(.KEY_WIDTH(KW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_abort (load_abort),
        .sdi        (sdi),
        .sdi_valid  (sdi_valid),
        .sdi_ready  (sdi_ready),
        .key        (key),
        .key_valid  (key_valid),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: one scoreboard pop per completed load.
    always @(negedge clk) begin
        logic ev;
        exp_t e;
        ev = rst_n && (key_valid || err);
        if (ev && !prev_ev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("scoreboard_result", 64'({key, key_valid, err}), 64'(e));
            end
        end
        prev_ev = ev;
    end

    // Expected outcome from the even-parity rule: total ones must be even.
    function automatic exp_t model(input logic [KW-1:0] bits, input logic par);
        exp_t e;
        if (($countones(bits) + int'(par)) % 2 == 0) begin
            e.k = bits; e.v = 1'b1; e.e = 1'b0;
        end else begin
            e.k = '0; e.v = 1'b0; e.e = 1'b1;
        end
        return e;
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // One cycle of serial input; x reports whether a transfer happened.
    task automatic cyc(input logic v, input logic b, output logic x);
        logic rdy;
        sdi_valid = v;
        sdi       = b;
        @(negedge clk);
        rdy = sdi_ready;
        sync();
        x = v && rdy;
    endtask

    task automatic drive_bit(input logic b);
        logic x;
        logic v;
        int   n;
        n = 0;
        x = 1'b0;
        while (!x && n < 100) begin
            v = ($urandom_range(0, 3) != 0);
            cyc(v, v ? b : 1'($urandom_range(0, 1)), x);
            n++;
        end
        if (!x) check("xfer_timeout", 64'd0, 64'd1);
        sdi_valid = 1'b0;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        sync();
        load_start = 1'b0;
        @(negedge clk);
        check("start_clears", 64'({key, key_valid, err, busy}), 64'({{KW{1'b0}}, 3'b001}));
        sync();
    endtask

    // Called right after the parity-accepting edge.
    task automatic finish_load(input exp_t e);
        sdi_valid = 1'b0;
        @(negedge clk);
        check("check_cycle", 64'({key_valid, err, busy, sdi_ready}), 64'(4'b0010));
        @(negedge clk);
        check("latency_result", 64'({key_valid, err, busy}), 64'({e.v, e.e, 1'b0}));
        sync();
        repeat (3) sync();
        @(negedge clk);
        check("result_hold", 64'({key, key_valid, err}), 64'(e));
        sync();
    endtask

    task automatic do_load(input logic [KW-1:0] bits, input logic par);
        exp_t e;
        e = model(bits, par);
        exp_q.push_back(e);
        start_load();
        for (int n = 0; n < KW; n++) drive_bit(bits[n]);
        drive_bit(par);
        finish_load(e);
    endtask

    initial begin
        logic x;
        rst_n      = 1'b1;
        load_start = 1'b0;
        load_abort = 1'b0;
        sdi        = 1'b0;
        sdi_valid  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("reset_outputs", 64'({key, key_valid, err, busy, sdi_ready}),
              64'({{KW{1'b0}}, 4'b0000}));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        sync();

        // Bits 1,0 parity 1 -> key 01.
        do_load(2'b01, 1'b1);

        // Abort from DONE clears the key.
        load_abort = 1'b1;
        sync();
        load_abort = 1'b0;
        @(negedge clk);
        check("abort_from_done", 64'({key, key_valid, err, busy}), 64'({{KW{1'b0}}, 3'b000}));
        sync();

        // Bits 1,1 parity 1 -> ERROR.
        do_load(2'b11, 1'b1);

        // Stalled transfers: valid 1,0,0,1,1 with bits 0,x,x,1,1 -> key 10.
        exp_q.push_back(model(2'b10, 1'b1));
        start_load();
        cyc(1'b1, 1'b0, x);
        cyc(1'b0, 1'b1, x);
        cyc(1'b0, 1'b1, x);
        cyc(1'b1, 1'b1, x);
        cyc(1'b1, 1'b1, x);
        finish_load(model(2'b10, 1'b1));

        // Abort concurrent with a transfer, then a clean load of 11 parity 0.
        start_load();
        cyc(1'b1, 1'b1, x);
        load_abort = 1'b1;
        cyc(1'b1, 1'b0, x);
        load_abort = 1'b0;
        sdi_valid  = 1'b0;
        @(negedge clk);
        check("abort_in_shift", 64'({key, key_valid, err, busy, sdi_ready}),
              64'({{KW{1'b0}}, 4'b0000}));
        sync();
        do_load(2'b11, 1'b0);

        // load_start in SHIFT is ignored; the first bit is kept.
        exp_q.push_back(model(2'b01, 1'b1));
        start_load();
        cyc(1'b1, 1'b1, x);
        load_start = 1'b1;
        cyc(1'b0, 1'b0, x);
        load_start = 1'b0;
        @(negedge clk);
        check("start_ignored", 64'({busy, sdi_ready}), 64'(2'b11));
        sync();
        cyc(1'b1, 1'b0, x);
        cyc(1'b1, 1'b1, x);
        finish_load(model(2'b01, 1'b1));

        // Asynchronous reset mid-SHIFT.
        start_load();
        cyc(1'b1, 1'b1, x);
        sdi_valid = 1'b0;
        check("pre_reset_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_mid_load", 64'({key, key_valid, err, busy, sdi_ready}),
              64'({{KW{1'b0}}, 4'b0000}));
        sync();
        rst_n = 1'b1;
        repeat (3) sync();
        check("idle_after_reset", 64'({busy, sdi_ready}), 64'(2'b00));

        // Reload from DONE.
        do_load(2'b01, 1'b1);
        do_load(2'b10, 1'b1);

        // Randomized loads, parity sometimes corrupted.
        for (int i = 0; i < 25; i++) begin
            logic [KW-1:0] b;
            logic          p;
            b = KW'($urandom);
            p = (^b) ^ ($urandom_range(0, 3) == 0);
            do_load(b, p);
        end

        repeat (5) sync();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
